// File: rtl/cdb_result_buffer_pkg.sv
// Shared CDB packet type and constants for the result buffer and the CDB scheduler.
// ROB entry 0 is reserved to mean "no packet" on the CDB.
package cdb_result_buffer_pkg;

  localparam logic [3:0] NULL_ROB_ENTRY = 4'b0;

  typedef struct packed {
    logic [3:0]  dest_ROB_entry;
    logic [31:0] result;
    logic        branch_result;
    logic        from_commit;
  } CDB_packet_t;

endpackage

// File: rtl/cdb_fifo_ctrl.sv
// Circular-buffer bookkeeping: head/tail pointers, occupancy, full/empty and flush.
// Storage lives in the parent so this block can be reused for other queues.
module cdb_fifo_ctrl #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_push_ok,
  output logic          o_pop_ok,
  output logic [PW-1:0] o_head,
  output logic [PW-1:0] o_tail,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Full blocks a push even if a pop happens in the same cycle: no yummi->ready path.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_empty   = (r_count == '0);
    w_push_ok = i_push && !w_full && !i_flush;
    w_pop_ok  = i_pop && !w_empty && !i_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop_ok)  r_head <= r_head + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_push_ok = w_push_ok;
  assign o_pop_ok  = w_pop_ok;
  assign o_head    = r_head;
  assign o_tail    = r_tail;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

// File: rtl/cdb_result_buffer.sv
// Per-unit output queue feeding the CDB scheduler with a valid/yummi handshake.
// Packets addressed to the null ROB entry are accepted and silently dropped.
module cdb_result_buffer
  import cdb_result_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fu_valid,
  input  CDB_packet_t                fu_packet,
  output logic                       fu_ready,
  output logic                       valid_out,
  output CDB_packet_t                packet_out,
  input  logic                       yummi_in,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  CDB_packet_t   r_mem [DEPTH];
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [PW-1:0] w_head;
  logic [PW-1:0] w_tail;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  assign w_push_req = fu_valid && (fu_packet.dest_ROB_entry != NULL_ROB_ENTRY);

  cdb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_req),
    .i_pop     (yummi_in),
    .i_flush   (flush),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok),
    .o_head    (w_head),
    .o_tail    (w_tail),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Entry contents need no reset; they are only observed when count says they are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_tail] <= fu_packet;
  end

  always_comb begin
    packet_out = '0;
    if (!w_empty) packet_out = r_mem[w_head];
  end

  assign fu_ready  = !w_full;
  assign valid_out = !w_empty;
  assign count     = w_count;

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Directed, table-driven bench for cdb_result_buffer with DEPTH = 2,
// plus a hand-written asynchronous reset sequence.
module tb_cdb_result_buffer;
  import cdb_result_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          fu_valid;
  CDB_packet_t   fu_packet;
  logic          fu_ready;
  logic          valid_out;
  CDB_packet_t   packet_out;
  logic          yummi_in;
  logic          flush;
  logic [CW-1:0] count;

  int compared;
  int mismatched;

  typedef struct {
    logic          fv;
    CDB_packet_t   pkt;
    logic          yum;
    logic          fl;
    logic          ev;
    logic          er;
    logic [CW-1:0] ec;
    CDB_packet_t   ep;
  } vec_t;

  vec_t tbl[$];

  cdb_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fu_valid   (fu_valid),
    .fu_packet  (fu_packet),
    .fu_ready   (fu_ready),
    .valid_out  (valid_out),
    .packet_out (packet_out),
    .yummi_in   (yummi_in),
    .flush      (flush),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic CDB_packet_t mk(input logic [3:0] d, input logic [31:0] r,
                                     input logic b, input logic f);
    CDB_packet_t p;
    p.dest_ROB_entry = d;
    p.result         = r;
    p.branch_result  = b;
    p.from_commit    = f;
    return p;
  endfunction

  function automatic void add(input logic fv, input CDB_packet_t pkt, input logic yum,
                              input logic fl, input logic ev, input logic er,
                              input logic [CW-1:0] ec, input CDB_packet_t ep);
    vec_t v;
    v.fv = fv; v.pkt = pkt; v.yum = yum; v.fl = fl;
    v.ev = ev; v.er = er; v.ec = ec; v.ep = ep;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic ev, input logic er,
                       input logic [CW-1:0] ec, input CDB_packet_t ep);
    compared++;
    if (valid_out !== ev) begin
      mismatched++;
      $display("FAIL %s valid_out got %0b want %0b", name, valid_out, ev);
    end
    compared++;
    if (fu_ready !== er) begin
      mismatched++;
      $display("FAIL %s fu_ready got %0b want %0b", name, fu_ready, er);
    end
    compared++;
    if (count !== ec) begin
      mismatched++;
      $display("FAIL %s count got %0d want %0d", name, count, ec);
    end
    compared++;
    if (packet_out !== ep) begin
      mismatched++;
      $display("FAIL %s packet_out got %h want %h", name, packet_out, ep);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    fu_valid  = v.fv;
    fu_packet = v.pkt;
    yummi_in  = v.yum;
    flush     = v.fl;
    #1;
    if (yummi_in && !valid_out) begin
      mismatched++;
      $display("FAIL %s yummi_in asserted while valid_out=0", name);
    end
    @(posedge clk);
    #1;
    check(name, v.ev, v.er, v.ec, v.ep);
  endtask

  initial begin
    CDB_packet_t nul;
    CDB_packet_t p;
    compared   = 0;
    mismatched = 0;
    nul        = '0;
    rst_n      = 1'b0;
    fu_valid   = 1'b0;
    fu_packet  = '0;
    yummi_in   = 1'b0;
    flush      = 1'b0;

    // idle / first enqueue / hold
    add(0, nul, 0, 0, 0, 1, 0, nul);
    add(1, mk(3, 32'hDEAD_BEEF, 0, 0), 0, 0, 1, 1, 1, mk(3, 32'hDEAD_BEEF, 0, 0));
    for (int i = 0; i < 5; i++)
      add(0, nul, 0, 0, 1, 1, 1, mk(3, 32'hDEAD_BEEF, 0, 0));
    add(0, nul, 1, 0, 0, 1, 0, nul);
    // fill to full, stall, refuse while popping, drain in order
    add(1, mk(5, 32'h55, 1, 0), 0, 0, 1, 1, 1, mk(5, 32'h55, 1, 0));
    add(1, mk(6, 32'h66, 0, 1), 0, 0, 1, 0, 2, mk(5, 32'h55, 1, 0));
    add(1, mk(7, 32'h77, 1, 1), 0, 0, 1, 0, 2, mk(5, 32'h55, 1, 0));
    add(1, mk(7, 32'h77, 1, 1), 1, 0, 1, 1, 1, mk(6, 32'h66, 0, 1));
    add(1, mk(7, 32'h77, 1, 1), 0, 0, 1, 0, 2, mk(6, 32'h66, 0, 1));
    add(0, nul, 1, 0, 1, 1, 1, mk(7, 32'h77, 1, 1));
    add(0, nul, 1, 0, 0, 1, 0, nul);
    // simultaneous enqueue/dequeue at count 1, 2*DEPTH+1 times for pointer wrap
    add(1, mk(9, 32'h900, 0, 0), 0, 0, 1, 1, 1, mk(9, 32'h900, 0, 0));
    for (int i = 1; i <= 2 * DEPTH + 1; i++)
      add(1, mk(9, 32'h900 + i, 0, 0), 1, 0, 1, 1, 1, mk(9, 32'h900 + i, 0, 0));
    add(0, nul, 1, 0, 0, 1, 0, nul);
    // null ROB entry is accepted but dropped
    add(1, mk(0, 32'hBAD, 1, 1), 0, 0, 0, 1, 0, nul);
    // flush beats same-cycle enqueue and dequeue
    add(1, mk(1, 32'h11, 0, 0), 0, 0, 1, 1, 1, mk(1, 32'h11, 0, 0));
    add(1, mk(2, 32'h22, 0, 0), 0, 0, 1, 0, 2, mk(1, 32'h11, 0, 0));
    add(1, mk(4, 32'h44, 0, 0), 1, 1, 0, 1, 0, nul);
    add(0, nul, 0, 0, 0, 1, 0, nul);

    #1;
    check("reset_hold", 0, 1, 0, nul);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset between clock edges with one entry held
    @(negedge clk);
    p         = mk(8, 32'h88, 0, 1);
    fu_valid  = 1'b1;
    fu_packet = p;
    yummi_in  = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    check("pre_async_rst", 1, 1, 1, p);
    @(negedge clk);
    fu_valid  = 1'b0;
    fu_packet = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, 1, 0, nul);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 0, 1, 0, nul);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
